// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/pause/lap FSM,
// seconds-tick gating, lap snapshot and display digit selection.
module stopwatch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        lap,
  input  logic        clear,
  input  logic        pulse_1s,
  input  logic [15:0] time_bcd,
  output logic        count_en,
  output logic        clr_time,
  output logic [15:0] disp_bcd,
  output logic [1:0]  state,
  output logic [3:0]  lap_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_LAP    = 2'd3;

  // Button vector bit order: {clear, pause, lap, start}
  logic [3:0]  w_btn;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_sync3;
  logic [1:0]  r_arm;
  logic        w_armed;
  logic [3:0]  w_ev;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_lap_cnt;
  logic [3:0]  w_lap_cnt_nxt;
  logic [15:0] r_snap;
  logic [15:0] w_snap_nxt;
  logic        w_clr_nxt;
  logic        w_running;
  logic        r_count_en;
  logic        r_clr_time;
  logic [15:0] r_disp;

  assign w_btn = {clear, pause, lap, start};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
      r_sync3 <= 4'd0;
      r_arm   <= 2'd0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
    end
  end

  // Edges are masked until sync3 has caught up with a level held through reset.
  assign w_armed = (r_arm == 2'd3);
  assign w_ev    = (r_sync2 & ~r_sync3) & {4{w_armed}};

  assign w_running = (r_state == ST_RUN) || (r_state == ST_LAP);

  always_comb begin
    w_state_nxt   = r_state;
    w_lap_cnt_nxt = r_lap_cnt;
    w_snap_nxt    = r_snap;
    w_clr_nxt     = 1'b0;
    // Priority clear > pause > lap > start; only the first legal event acts.
    if (w_ev[3] && ((r_state == ST_IDLE) || (r_state == ST_PAUSED))) begin
      w_state_nxt   = ST_IDLE;
      w_lap_cnt_nxt = 4'd0;
      w_clr_nxt     = 1'b1;
    end else if (w_ev[2] && w_running) begin
      w_state_nxt = ST_PAUSED;
    end else if (w_ev[1] && w_running) begin
      w_state_nxt = ST_LAP;
      w_snap_nxt  = time_bcd;
      if (r_lap_cnt != 4'd15) w_lap_cnt_nxt = r_lap_cnt + 4'd1;
    end else if (w_ev[0] && (r_state != ST_RUN)) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lap_cnt  <= 4'd0;
      r_snap     <= 16'd0;
      r_clr_time <= 1'b0;
      r_count_en <= 1'b0;
      r_disp     <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_lap_cnt  <= w_lap_cnt_nxt;
      r_snap     <= w_snap_nxt;
      r_clr_time <= w_clr_nxt;
      r_count_en <= pulse_1s && w_running;
      r_disp     <= (r_state == ST_LAP) ? r_snap : time_bcd;
    end
  end

  assign count_en = r_count_en;
  assign clr_time = r_clr_time;
  assign disp_bcd = r_disp;
  assign state    = r_state;
  assign lap_cnt  = r_lap_cnt;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: event-level reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = 4'd0;  // {clear, pause, lap, start}
  logic        pulse_1s = 1'b0;
  logic [15:0] time_bcd = 16'd0;
  logic        count_en;
  logic        clr_time;
  logic [15:0] disp_bcd;
  logic [1:0]  state;
  logic [3:0]  lap_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_LAP   = 4'b0010;
  localparam logic [3:0] B_PAUSE = 4'b0100;
  localparam logic [3:0] B_CLEAR = 4'b1000;

  stopwatch_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (btn[0]),
    .pause    (btn[2]),
    .lap      (btn[1]),
    .clear    (btn[3]),
    .pulse_1s (pulse_1s),
    .time_bcd (time_bcd),
    .count_en (count_en),
    .clr_time (clr_time),
    .disp_bcd (disp_bcd),
    .state    (state),
    .lap_cnt  (lap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a button level sampled high at edge k after a low sample
  // at edge k-1 acts at edge k+2, provided both samples were taken after reset.
  int          m_state = 0;
  int          m_lap = 0;
  logic [15:0] m_snap = 16'd0;
  logic [15:0] m_disp = 16'd0;
  logic        m_cen = 1'b0;
  logic        m_clr = 1'b0;
  logic [3:0]  lvl_q[$];
  logic [3:0]  m_ev;
  int          m_old;
  int          m_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_lap = 0; m_snap = 16'd0; m_disp = 16'd0;
      m_cen = 1'b0; m_clr = 1'b0;
      lvl_q.delete();
    end else begin
      lvl_q.push_back(btn);
      m_n  = lvl_q.size() - 1;
      m_ev = 4'd0;
      if (m_n >= 3) m_ev = lvl_q[m_n-2] & ~lvl_q[m_n-3];
      m_old  = m_state;
      m_cen  = pulse_1s && (m_old == 1 || m_old == 3);
      m_disp = (m_old == 3) ? m_snap : time_bcd;
      m_clr  = 1'b0;
      if (m_ev[3] && (m_old == 0 || m_old == 2)) begin
        m_state = 0; m_lap = 0; m_clr = 1'b1;
      end else if (m_ev[2] && (m_old == 1 || m_old == 3)) begin
        m_state = 2;
      end else if (m_ev[1] && (m_old == 1 || m_old == 3)) begin
        m_state = 3; m_snap = time_bcd;
        if (m_lap < 15) m_lap = m_lap + 1;
      end else if (m_ev[0] && m_old != 1) begin
        m_state = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_state", {14'd0, state}, 16'(m_state));
    chk("m_lap_cnt", {12'd0, lap_cnt}, 16'(m_lap));
    chk("m_count_en", {15'd0, count_en}, {15'd0, m_cen});
    chk("m_clr_time", {15'd0, clr_time}, {15'd0, m_clr});
    chk("m_disp_bcd", disp_bcd, m_disp);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    cyc(3);
    btn = 4'd0;
    cyc(3);
  endtask

  task automatic tick(input string name, input logic exp);
    pulse_1s = 1'b1;
    cyc(1);
    pulse_1s = 1'b0;
    chk(name, {15'd0, count_en}, {15'd0, exp});
    cyc(1);
  endtask

  initial begin
    cyc(3);
    chk("rst_state", {14'd0, state}, 16'd0);
    chk("rst_disp", disp_bcd, 16'd0);
    rst = 1'b0;
    cyc(4);
    tick("idle_tick", 1'b0);

    // Start latency: acts at the second edge after the first sample
    time_bcd = 16'h0005;
    btn = B_START;
    cyc(2);
    chk("start_early", {14'd0, state}, 16'd0);
    cyc(1);
    chk("start_lat", {14'd0, state}, 16'd1);
    btn = 4'd0;
    cyc(3);
    for (int i = 0; i < 3; i++) begin
      cyc(8);
      tick("run_tick", 1'b1);
    end

    // Lap freeze
    time_bcd = 16'h0127;
    btn = B_LAP;
    cyc(3);
    chk("lap_state", {14'd0, state}, 16'd3);
    chk("lap_cnt1", {12'd0, lap_cnt}, 16'd1);
    btn = 4'd0;
    cyc(1);
    chk("lap_disp", disp_bcd, 16'h0127);
    time_bcd = 16'h0130;
    tick("lap_tick", 1'b1);
    cyc(3);
    chk("lap_frozen", disp_bcd, 16'h0127);
    btn = B_START;
    cyc(3);
    chk("resume_state", {14'd0, state}, 16'd1);
    btn = 4'd0;
    cyc(1);
    chk("resume_live", disp_bcd, 16'h0130);
    cyc(2);

    // Pause with a tick in the edge-detect cycle: tick forwarded
    btn = B_PAUSE;
    cyc(2);
    pulse_1s = 1'b1;
    cyc(1);
    pulse_1s = 1'b0;
    chk("pause_tick_fwd", {15'd0, count_en}, 16'd1);
    chk("pause_state", {14'd0, state}, 16'd2);
    btn = 4'd0;
    cyc(3);
    tick("paused_tick", 1'b0);

    // Start from PAUSED with a tick in the edge-detect cycle: tick dropped
    btn = B_START;
    cyc(2);
    pulse_1s = 1'b1;
    cyc(1);
    pulse_1s = 1'b0;
    chk("start_tick_drop", {15'd0, count_en}, 16'd0);
    chk("start_state", {14'd0, state}, 16'd1);
    btn = 4'd0;
    cyc(3);

    // Clear in RUN is ignored; clear in PAUSED returns to IDLE
    press(B_CLEAR);
    chk("clr_run_state", {14'd0, state}, 16'd1);
    chk("clr_run_lap", {12'd0, lap_cnt}, 16'd1);
    press(B_PAUSE);
    btn = B_CLEAR;
    cyc(3);
    chk("clr_pulse", {15'd0, clr_time}, 16'd1);
    chk("clr_state", {14'd0, state}, 16'd0);
    chk("clr_lap", {12'd0, lap_cnt}, 16'd0);
    cyc(1);
    chk("clr_one_cycle", {15'd0, clr_time}, 16'd0);
    btn = 4'd0;
    cyc(3);

    // Priority
    press(B_START);
    time_bcd = 16'h0200;
    press(B_PAUSE | B_LAP);
    chk("prio_state", {14'd0, state}, 16'd2);
    chk("prio_lap", {12'd0, lap_cnt}, 16'd0);
    btn = B_CLEAR | B_START;
    cyc(3);
    chk("prio_clr", {15'd0, clr_time}, 16'd1);
    chk("prio_idle", {14'd0, state}, 16'd0);
    btn = 4'd0;
    cyc(3);

    // Hold lap for 100 cycles: one event
    press(B_START);
    btn = B_LAP;
    cyc(100);
    btn = 4'd0;
    cyc(3);
    chk("hold_lap", {12'd0, lap_cnt}, 16'd1);
    chk("hold_state", {14'd0, state}, 16'd3);

    // Saturation: laps 2..17
    for (int i = 2; i <= 17; i++) begin
      time_bcd = {8'h03, 4'(i / 10), 4'(i % 10)};
      press(B_LAP);
    end
    chk("sat_lap", {12'd0, lap_cnt}, 16'd15);
    chk("sat_snap", disp_bcd, 16'h0317);

    // Lap coinciding with count_en keeps the pre-increment time
    press(B_PAUSE);
    press(B_CLEAR);
    press(B_START);
    press(B_LAP);
    press(B_LAP);
    time_bcd = 16'h0458;
    btn = B_LAP;
    cyc(1);
    pulse_1s = 1'b1;
    cyc(1);
    pulse_1s = 1'b0;
    chk("coinc_cen", {15'd0, count_en}, 16'd1);
    cyc(1);
    time_bcd = 16'h0459;
    btn = 4'd0;
    cyc(1);
    chk("coinc_snap", disp_bcd, 16'h0458);
    chk("coinc_lap", {12'd0, lap_cnt}, 16'd3);
    cyc(2);
    press(B_START);
    chk("pre_rst_state", {14'd0, state}, 16'd1);

    // Asynchronous reset mid-RUN, then release with start held
    #3 rst = 1'b1;
    #1;
    chk("arst_state", {14'd0, state}, 16'd0);
    chk("arst_lap", {12'd0, lap_cnt}, 16'd0);
    chk("arst_disp", disp_bcd, 16'd0);
    chk("arst_cen", {15'd0, count_en}, 16'd0);
    chk("arst_clr", {15'd0, clr_time}, 16'd0);
    btn = B_START;
    cyc(2);
    rst = 1'b0;
    cyc(8);
    chk("held_start", {14'd0, state}, 16'd0);
    btn = 4'd0;
    cyc(3);
    press(B_START);
    chk("post_rst_start", {14'd0, state}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
